sram_controller: RTL
====================

# sram_controller

Sequences 32-bit load/store requests from the memory stage onto a 16-bit asynchronous SRAM as two half-word phases. Drives the pipeline `SRAM_freeze` signal that holds the EXE/MEM pipeline register and every stage upstream of it while an access is in flight. Sits between the memory stage and the board SRAM pins.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM half-word 0.
- `PHASE_CYCLES`, default 2: cycles per half-word phase; legal range 2–15.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  load request from the EXE/MEM register.
- `mem_write`  in  1  store request from the EXE/MEM register.
- `address`  in  32  byte address, which is the ALU result.
- `write_data`  in  32  store data, which is reg2.
- `read_data`  out  32  load result.
- `SRAM_freeze`  out  1  stall for the pipeline registers.
- `ready`  out  1  equals `~SRAM_freeze`.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_dq_o`  out  16  data driven to the SRAM.
- `sram_dq_oe`  out  1  tri-state enable for `sram_dq_o`.
- `sram_dq_i`  in  16  data returned by the SRAM.
- `addr_err`  out  1  sticky range-error flag; present only with the macro defined (see Configuration).

## Operation
- **States:** IDLE, LOW, HIGH, DONE, with a 4-bit phase counter `cnt`.
- **IDLE, request present** (`mem_read | mem_write`):
  - Combinationally assert `SRAM_freeze=1`.
  - Latch `op`, `address` and `write_data`.
  - Clear `cnt` and go to LOW.
- **IDLE, no request:** `SRAM_freeze=0`.
- **Simultaneous `mem_read` and `mem_write`:** the write wins.
- **Address mapping:** `off = address - BASE_ADDR` in 32-bit wrap arithmetic. `sram_addr = {off[18:2], half}`, where `half=0` in LOW and `half=1` in HIGH.
- **LOW / HIGH phase behaviour:**
  - `cnt` counts from 0 to `PHASE_CYCLES-1`.
  - `sram_addr` is stable for the whole phase.
  - **Write:**
    - `sram_dq_oe=1` for the whole phase.
    - `sram_dq_o` is the latched data bits [15:0] in LOW and bits [31:16] in HIGH.
    - `sram_we_n=0` while `cnt≥1`, so the first cycle gives address setup.
  - **Read:** `sram_dq_oe=0` and `sram_we_n=1`. When `cnt==PHASE_CYCLES-1`, capture `sram_dq_i` into `read_data[15:0]` (LOW) or `read_data[31:16]` (HIGH).
  - **Phase end:** LOW→HIGH and HIGH→DONE, each when `cnt==PHASE_CYCLES-1`.
- **DONE:**
  - `SRAM_freeze=0`, so the pipeline advances on this edge.
  - `read_data` is valid.
  - Go to IDLE unconditionally; a new request is accepted on the following cycle.
- **`read_data` hold:** holds its last value until the next read captures.
- **Write data:** unchanged in `read_data`; `write_data` is never forwarded.
- **Inputs during an access:** changes to inputs after the IDLE latch are ignored.

## Timing
- **Frozen cycles per access:** `1 + 2*PHASE_CYCLES`. The default is 5, with `ready` high on the 6th cycle.
- **Back-to-back accesses:** one idle-gap cycle (DONE) between them, where `ready=1`.
- **Freeze path:** `SRAM_freeze` is combinational from state plus the request inputs in IDLE, and registered-state-only elsewhere.
- **Reset values:**
  - State IDLE, `cnt=0`.
  - `read_data=0`, `sram_addr=0`, `sram_dq_o=0`.
  - `sram_we_n=1`, `sram_dq_oe=0`.
  - `addr_err=0`.
  - `SRAM_freeze` follows the request inputs through the IDLE rule.
- **Reset mid-access:** aborts immediately with no completion cycle. A partially written word may remain in the SRAM.

## Configuration
- **`SRAM_ADDR_CHECK_EN` defined:**
  - An access is out of range if `address < BASE_ADDR`, `off ≥ 2^19`, or `address[1:0] != 0`.
  - An out-of-range access skips LOW/HIGH and goes IDLE→DONE, for one frozen cycle.
  - No SRAM strobe is issued and `read_data` is unchanged.
  - `addr_err` sets and stays set until `rst`.
- **Not defined:**
  - No check is made, and the address truncates per the mapping.
  - The `addr_err` port is absent.

## Structure
- **Shared package `sram_pkg`:** the state enum (IDLE/LOW/HIGH/DONE), the op encoding, and the constants `SRAM_AW=18`, `SRAM_DW=16`, `SRAM_BYTES=2^19`.
- **Sub-module `sram_phase_timer`:** the phase counter, producing `phase_last` and `we_window` from `start` and `PHASE_CYCLES`. It is instantiated once.
- **Top level:** the FSM, latches and pin muxing.

## Test plan
- **Write then read:** write `0xDEADBEEF` to `address` 1024, then read it back.
  - Expect `sram_addr` 0 then 1.
  - Expect `sram_dq_o` `0xBEEF` then `0xDEAD`.
  - Expect `sram_we_n` low for 1 cycle per phase.
  - Expect freeze for exactly 5 cycles per access.
  - Expect the read to return `0xDEADBEEF` in DONE.
- **Back-to-back writes:** stores to 1028 and 1032 give `sram_addr` 2,3 and then 4,5, with exactly one `ready` cycle between them.
- **Simultaneous read and write:** `mem_read=mem_write=1` performs the write only; `read_data` is unchanged.
- **Reset mid-access:** assert `rst` in HIGH cycle 0. Outputs go to reset values asynchronously, the state is IDLE, and freeze is 0 once requests are low.
- **`PHASE_CYCLES=4`:** a read freezes for 9 cycles, and data is sampled on `cnt==3` of each phase.
- **With `SRAM_ADDR_CHECK_EN`, out of range:** a read at 1000 freezes for 1 cycle, no strobe is issued, and `addr_err=1` and stays set.
- **With `SRAM_ADDR_CHECK_EN`, misaligned:** an access at 1026 also sets `addr_err`.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } sram_op_e;

  localparam int          SRAM_AW    = 18;
  localparam int          SRAM_DW    = 16;
  localparam logic [31:0] SRAM_BYTES = 32'h0008_0000;

  // Below the window, beyond the SRAM, or not word aligned.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || (off >= SRAM_BYTES) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Phase counter: counts 0..PHASE_CYCLES-1 while run is high, cleared by start
// and at the end of every phase.
module sram_phase_timer #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic phase_last,
  output logic we_window
);

  localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start || (run && (cnt_q == LAST))) begin
      cnt_d = 4'd0;
    end else if (run) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_last = run && (cnt_q == LAST);
  // Cycle 0 of each phase is address setup; the strobe may only follow it.
  assign we_window  = run && (cnt_q != 4'd0);

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit loads/stores into two 16-bit SRAM phases and freezes the pipeline.
// Optional range checking with sticky addr_err is enabled by SRAM_ADDR_CHECK_EN.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int          PHASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               SRAM_freeze,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i,
`ifdef SRAM_ADDR_CHECK_EN
  output logic               addr_err,
`endif
  output logic [1:0]         dbg_state
);

  sram_state_e state_q, state_d;
  sram_op_e    op_q, op_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        start;
  logic        run;
  logic        is_high;
  logic        is_write;
  logic        phase_last;
  logic        we_window;
  logic        range_bad;
  logic [31:0] off_in;

  assign req    = mem_read | mem_write;
  assign off_in = address - BASE_ADDR;

`ifdef SRAM_ADDR_CHECK_EN
  logic err_q, err_d;
  logic [14:0] unused_off_bits;
  assign range_bad       = addr_out_of_range(address, BASE_ADDR);
  assign unused_off_bits = {off_in[31:19], off_in[1:0]};
`else
  logic [14:0] unused_off_bits;
  assign range_bad       = 1'b0;
  assign unused_off_bits = {off_in[31:19], off_in[1:0]};
`endif

  sram_phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .run       (run),
    .phase_last(phase_last),
    .we_window (we_window)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    SRAM_freeze = 1'b0;
    start       = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          SRAM_freeze = 1'b1;
          start       = 1'b1;
          // A store beats a load when both are requested.
          op_d        = mem_write ? OP_WRITE : OP_READ;
          word_d      = off_in[18:2];
          wdata_d     = write_data;
          if (range_bad) begin
            state_d = ST_DONE;
`ifdef SRAM_ADDR_CHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        SRAM_freeze = 1'b1;
        if (phase_last) begin
          state_d = ST_HIGH;
          if (op_q == OP_READ) rdata_d[15:0] = sram_dq_i;
        end
      end
      ST_HIGH: begin
        SRAM_freeze = 1'b1;
        if (phase_last) begin
          state_d = ST_DONE;
          if (op_q == OP_READ) rdata_d[31:16] = sram_dq_i;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign addr_err = err_q;
`endif

  // Pins are decoded from registered state only, so they are glitch-free per phase.
  assign run        = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign is_high    = (state_q == ST_HIGH);
  assign is_write   = (op_q == OP_WRITE);
  assign sram_addr  = run ? {word_q, is_high} : '0;
  assign sram_dq_oe = run && is_write;
  assign sram_we_n  = ~(run && is_write && we_window);
  assign sram_dq_o  = sram_dq_oe ? (is_high ? wdata_q[31:16] : wdata_q[15:0]) : '0;

  assign read_data  = rdata_q;
  assign ready      = ~SRAM_freeze;
  assign dbg_state  = state_q;

endmodule
